beg_task_queue: RTL
===================

Name: beg_task_queue

Overview:
- Receive side of the scheduler "begin" path: captures gated 4-bit task IDs produced by the begin-select mux stage.
- The mux stage drives the ID when its select is high and 4'd0 otherwise.
- Buffers accepted IDs in a FIFO and dispatches them in arrival order to the execution side over a valid/ready handshake.
- Task ID 0 is reserved as "no task" and is never queued.

Parameters:
- ID_W, 4, task ID width (matches the begin mux output width)
- DEPTH, 8, FIFO entries (power of two)
- PTR_W, 3, log2(DEPTH)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- beg_sel  input  1  begin strobe from the begin mux select
- beg_id  input  ID_W  gated task ID from the begin mux (0 when beg_sel=0)
- disp_ready  input  1  execution side can take a task this cycle
- disp_valid  output  1  head entry available
- disp_id  output  ID_W  head task ID, valid when disp_valid=1
- count  output  PTR_W+1  number of stored entries, 0..DEPTH
- full  output  1  count==DEPTH
- empty  output  1  count==0
- ovf  output  1  sticky overflow flag

Behaviour:
- Reset (rst=1 at clk edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, disp_valid=0, disp_id=0, ovf=0. The storage array is not cleared.
- rst is sampled on the clock edge only and overrides all other inputs in that cycle. Reset mid-operation discards all stored entries.
- push_req = beg_sel & (beg_id != 0). beg_sel=1 with beg_id=0 is ignored: no push, no flag.
- pop = disp_valid & disp_ready.
- push = push_req & (~full | pop). A write to a full FIFO is accepted only when a pop occurs in the same cycle.
- Dropped push (push_req & full & ~pop): entry discarded, ovf set to 1 next cycle, ovf held until reset.
- On push: mem[wr_ptr] <= beg_id; wr_ptr increments, wrapping DEPTH-1 -> 0.
- On pop: rd_ptr increments, wrapping DEPTH-1 -> 0.
- count update: +1 on push only, -1 on pop only, unchanged on push & pop or on neither.
- Outputs are first-word-fall-through and registered from state:
  - disp_valid = ~empty.
  - disp_id = mem[rd_ptr] when ~empty, else 0.
- Latency: an ID pushed at edge N appears on disp_id/disp_valid after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Simultaneous push & pop when empty cannot occur, because pop requires disp_valid.
- Simultaneous push & pop when count=1: head pops and the new entry becomes head next cycle, so disp_valid stays 1.
- disp_ready with empty FIFO: no effect.
- disp_id and disp_valid must stay stable while disp_valid=1 & disp_ready=0.
- full and empty are derived from count, never both 1.
- Duplicate IDs are queued independently; no deduplication.

Test Plan:
- Reset then idle, beg_sel=0 -> disp_valid=0, disp_id=0, count=0, empty=1, ovf=0 for 10 cycles.
- Push IDs 3,7,12 on consecutive cycles with disp_ready=0 -> count=3; disp_id=3 held stable; then disp_ready=1 for 3 cycles -> dispatch order 3,7,12, then empty=1, disp_id=0.
- beg_sel=1 with beg_id=0 for 4 cycles -> count stays 0, ovf=0.
- Fill 8 entries (IDs 1..8), then push ID 9 with disp_ready=0 -> full=1, count=8, ovf=1. Drain -> outputs 1..8 only; ovf remains 1.
- Full FIFO, push ID 15 with disp_ready=1 in the same cycle -> ID 1 popped, 15 accepted, count stays 8, ovf=0. Drain order 2..8,15 confirms pointer wrap.
- Push 5 entries, assert rst for 1 cycle while beg_sel=1, beg_id=6 -> after the edge count=0, disp_valid=0, ovf=0, and ID 6 is not stored.

Source files
------------

// File: rtl/beg_task_queue.sv
// Receive-side task queue for the scheduler begin path: captures non-zero task
// IDs from the begin mux and dispatches them in arrival order (FWFT, valid/ready).
module beg_task_queue #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beg_sel,
  input  logic [ID_W-1:0]  beg_id,
  input  logic             disp_ready,
  output logic             disp_valid,
  output logic [ID_W-1:0]  disp_id,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pushReq, push, pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign count      = count_q;
  assign ovf        = ovf_q;
  assign disp_valid = ~empty;
  assign disp_id    = empty ? '0 : mem_q[rdPtr_q];

  // ID 0 means "no task", so a select with a zero ID is not a request.
  assign pushReq = beg_sel & (beg_id != '0);
  assign pop     = disp_valid & disp_ready;
  assign push    = pushReq & (~full | pop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (pushReq & full & ~pop);
    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is intentionally left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wrPtr_q] <= beg_id;
  end

endmodule
